// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle: source/destination info in, stall/forward/flush controls out.
interface hazard_scoreboard_if #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5
);
  localparam int SELW = $clog2(DEPTH);
  localparam int INFW = $clog2(DEPTH + 1);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_rs1_use_i;
  logic              id_rs2_use_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwr_i;
  logic              id_load_i;
  logic              redirect_i;
  logic              mem_ready_i;
  logic              stall_o;
  logic              freeze_o;
  logic              flush_o;
  logic [SELW-1:0]   fwd1_sel_o;
  logic [SELW-1:0]   fwd2_sel_o;
  logic [INFW-1:0]   inflight_o;
  logic [31:0]       stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
    output id_rd_i, id_regwr_i, id_load_i, redirect_i, mem_ready_i,
    input  stall_o, freeze_o, flush_o, fwd1_sel_o, fwd2_sel_o, inflight_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
    input  id_rd_i, id_regwr_i, id_load_i, redirect_i, mem_ready_i,
    output stall_o, freeze_o, flush_o, fwd1_sel_o, fwd2_sel_o, inflight_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight writers after ID, detects RAW hazards,
// selects forwarding sources, and generates stall/flush/freeze controls.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int REG_AW   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_scoreboard_if.slave sb
);
  localparam int SELW = $clog2(DEPTH);
  localparam int INFW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  load_q, load_d;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [REG_AW-1:0] rd_d [DEPTH];
  logic [INFW-1:0]   inflight_q, inflight_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]  rdy_s;
  logic [DEPTH-1:0]  m1_s, m2_s;
  logic [SELW-1:0]   idx1_s, idx2_s;
  logic              hit1_s, hit2_s;
  logic              ok1_s, ok2_s;
  logic              stall_s, freeze_s;
  logic [SELW-1:0]   sel1_s, sel2_s;

  // Lowest-index set bit wins: the youngest writer holds the newest value.
  function automatic logic [SELW-1:0] first_idx(input logic [DEPTH-1:0] v);
    logic [SELW-1:0] idx;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v[k]) begin
        idx = SELW'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [INFW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [INFW-1:0] c;
    c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      c = c + INFW'(v[k]);
    end
    return c;
  endfunction

  // Per-slot readiness and per-source writer match vectors
  always_comb begin
    rdy_s = '0;
    m1_s  = '0;
    m2_s  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rdy_s[k] = (k >= 1) && ((load_q[k] == 1'b0) || (k >= LOAD_LAT));
      m1_s[k]  = valid_q[k] && (rd_q[k] != '0) && (rd_q[k] == sb.id_rs1_i)
                 && sb.id_rs1_use_i && (sb.id_rs1_i != '0);
      m2_s[k]  = valid_q[k] && (rd_q[k] != '0) && (rd_q[k] == sb.id_rs2_i)
                 && sb.id_rs2_use_i && (sb.id_rs2_i != '0);
    end
  end

  // Hazard resolution: forward from a ready match, stall on an unready one
  always_comb begin
    idx1_s   = first_idx(m1_s);
    idx2_s   = first_idx(m2_s);
    hit1_s   = |m1_s;
    hit2_s   = |m2_s;
    ok1_s    = hit1_s && rdy_s[idx1_s];
    ok2_s    = hit2_s && rdy_s[idx2_s];
    sel1_s   = ok1_s ? idx1_s : '0;
    sel2_s   = ok2_s ? idx2_s : '0;
    stall_s  = sb.id_valid_i && ((hit1_s && !ok1_s) || (hit2_s && !ok2_s));
    freeze_s = !sb.mem_ready_i;
  end

  // Slot shift, bubble insertion and stall counting; everything holds while frozen
  always_comb begin
    valid_d     = valid_q;
    load_d      = load_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze_s) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      valid_d[0] = sb.id_valid_i && sb.id_regwr_i && !stall_s;
      load_d[0]  = sb.id_load_i;
      rd_d[0]    = sb.id_rd_i;
      if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    inflight_d = popcount(valid_d);
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      load_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
      inflight_q  <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.stall_o     = stall_s;
  assign sb.freeze_o    = freeze_s;
  assign sb.flush_o     = sb.redirect_i && !stall_s && !freeze_s;
  assign sb.fwd1_sel_o  = sel1_s;
  assign sb.fwd2_sel_o  = sel2_s;
  assign sb.inflight_o  = inflight_q;
  assign sb.stall_cnt_o = stall_cnt_q;
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: in-flight writer slots after ID (slot 0 = EX, slot DEPTH-1 = WB); legal range >=2.
REQ-002 Parameter LOAD_LAT, default 2: lowest slot index at which load data can be forwarded; legal range 1..DEPTH-1.
REQ-003 Parameter REG_AW, default 5: register address width.
REQ-004 Derived constant SELW = clog2(DEPTH).
REQ-005 clk_i  in  1  the single clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 id_valid_i  in  1  ID holds a live instruction.
REQ-008 id_rs1_i, id_rs2_i  in  REG_AW each  source register addresses.
REQ-009 id_rs1_use_i, id_rs2_use_i  in  1 each  source is actually read.
REQ-010 id_rd_i  in  REG_AW  destination register.
REQ-011 id_regwr_i  in  1  instruction writes rd.
REQ-012 id_load_i  in  1  instruction is a load.
REQ-013 redirect_i  in  1  taken branch resolved in ID this cycle.
REQ-014 mem_ready_i  in  1  data memory can complete; 0 freezes the pipe.
REQ-015 stall_o  out  1  data hazard: hold PC and IF/ID, inject bubble into EX.
REQ-016 freeze_o  out  1  equals ~mem_ready_i; hold every pipeline register.
REQ-017 flush_o  out  1  kill the instruction in IF/ID.
REQ-018 fwd1_sel_o, fwd2_sel_o  out  SELW each  0 = register file, k = result of slot k.
REQ-019 inflight_o  out  clog2(DEPTH+1)  count of valid slots.
REQ-020 stall_cnt_o  out  32  cycles with stall_o=1 and freeze_o=0, saturating.

Function
REQ-021 Each slot stores {valid, rd, load}; a slot is a writer only when valid=1 and rd!=0.
REQ-022 Slot k is ready when k >= 1 for non-loads and k >= LOAD_LAT for loads; slot 0 is never ready.
REQ-023 For each used source, the match is the lowest-index writer slot whose rd equals the source; no match gives select 0.
REQ-024 Source address 0, or a use flag of 0, always gives select 0 and never causes a stall.
REQ-025 stall_o = id_valid_i AND (some used source has a match that is not ready); stall_o is combinational.
REQ-026 fwd*_sel_o is the matched slot index when it is ready, otherwise 0; all selects are combinational.
REQ-027 flush_o = redirect_i AND ~stall_o AND ~freeze_o; while the branch operands are unresolved, redirect_i is ignored.
REQ-028 When freeze_o=1, all slots and stall_cnt_o hold.
REQ-029 When freeze_o=0, slot k+1 takes slot k at the clock edge, and the slot at DEPTH-1 retires.
REQ-030 When freeze_o=0, slot 0 takes {id_valid_i & id_regwr_i, id_rd_i, id_load_i}.
REQ-031 In REQ-030, slot 0 is loaded as invalid when stall_o=1 (bubble).
REQ-032 inflight_o is the population count of slot valid bits, registered state, 0..DEPTH.
REQ-033 stall_cnt_o increments by 1 on each unfrozen stall cycle and saturates at 0xFFFFFFFF without wrapping.
REQ-034 A hazard with the WB slot (DEPTH-1) is forwarded through select DEPTH-1; no register-file write-through is required.

Reset
REQ-035 While rst_i=1, all slot valid bits = 0 immediately, and inflight_o = 0 and stall_cnt_o = 0 immediately.
REQ-036 While rst_i=1, combinational outputs follow the empty state: stall_o=0 and fwd selects 0; flush_o and freeze_o follow their inputs.
REQ-037 Reset asserted mid-stall or mid-freeze discards all in-flight slots; the first edge after release loads slot 0 from ID.

Verification
REQ-038 DEPTH=3, LOAD_LAT=2; add x5 issued, next ID add reads x5 -> stall_o=1 one cycle, then fwd1_sel_o=1, stall_cnt_o=1.
REQ-039 lw x7 issued, next ID reads x7 in rs2 -> stall_o=1 two cycles, then fwd2_sel_o=2, stall_cnt_o=2.
REQ-040 Writer rd=x0 in slot 0, consumer reads x0 -> stall_o=0, selects 0; x5 in slots 1 and 2 -> select 1 (youngest).
REQ-041 mem_ready_i=0 three cycles during a load-use stall -> freeze_o=1, slots and stall_cnt_o frozen; stall resumes after release.
REQ-042 redirect_i=1 with an unready branch operand -> flush_o=0; operand ready -> flush_o=1 in the same cycle.
REQ-043 rst_i pulsed asynchronously with 3 slots valid -> inflight_o=0 and stall_o=0 before the next clock edge.
